sc_mul_scheduler: RTL and testbench

Round-robin scheduler that shares one `sobol_32` stochastic-computing multiplier among `NUM_REQ` requesters. Each requester presents a pair of 6-bit unipolar operands. The scheduler grants one request per cycle, drives the shared multiplier from a registered operand stage, popcounts the 32-bit AND-bitstream, and returns a tagged product count through a valid/ready response port. It sits between PE-side operand producers and the SC result collector.

---
 rtl/sc_mul_scheduler.sv | 137 +++++++++++++
 tb/tb_sc_mul_scheduler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_mul_scheduler.sv
// Round-robin scheduler sharing one stochastic multiplier among requesters.
// Two-stage pipeline: registered operands (S1) and tagged popcount response (S2).
module sc_mul_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int SOBOL_W = 6,
    parameter int BS_W    = 32,
    parameter int CNT_W   = 6,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*SOBOL_W-1:0] req_a,
    input  logic [NUM_REQ*SOBOL_W-1:0] req_b,
    output logic [SOBOL_W-1:0]         mul_a,
    output logic [SOBOL_W-1:0]         mul_b,
    input  logic [BS_W-1:0]            mul_c,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [CNT_W-1:0]           rsp_count,
    output logic                       busy
);

    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic               s1_valid_q, s1_valid_d;
    logic [ID_W-1:0]    s1_id_q, s1_id_d;
    logic [SOBOL_W-1:0] mul_a_q, mul_a_d;
    logic [SOBOL_W-1:0] mul_b_q, mul_b_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [CNT_W-1:0]   rsp_count_q, rsp_count_d;

    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    int                 cand;
    logic               s1_advance;
    logic               s1_accept;
    logic               handshake;
    logic [CNT_W-1:0]   popcnt;

    // Search upward from rr_ptr, wrapping, for the first valid requester.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand);
            end
        end
    end

    always_comb begin
        popcnt = '0;
        for (int i = 0; i < BS_W; i++) begin
            popcnt = popcnt + CNT_W'(mul_c[i]);
        end
    end

    assign s1_advance = s1_valid_q & (~rsp_valid_q | rsp_ready);
    assign s1_accept  = ~s1_valid_q | s1_advance;
    // No handshake may complete while reset is held.
    assign handshake  = grant_found & s1_accept & ~rst;

    always_comb begin
        req_ready = '0;
        if (handshake) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        s1_valid_d  = s1_valid_q;
        s1_id_d     = s1_id_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_count_d = rsp_count_q;

        if (s1_advance) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = s1_id_q;
            rsp_count_d = popcnt;
            s1_valid_d  = 1'b0;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        if (handshake) begin
            s1_valid_d = 1'b1;
            s1_id_d    = grant_idx;
            mul_a_d    = req_a[int'(grant_idx)*SOBOL_W +: SOBOL_W];
            mul_b_d    = req_b[int'(grant_idx)*SOBOL_W +: SOBOL_W];
            if (grant_idx == ID_W'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + ID_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_count_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_count_q <= rsp_count_d;
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_count = rsp_count_q;
    assign busy      = s1_valid_q | rsp_valid_q;

endmodule

// File: tb/tb_sc_mul_scheduler.sv
// Directed bench for sc_mul_scheduler with a behavioural stochastic multiplier.
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_sc_mul_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [23:0] req_a;
    logic [23:0] req_b;
    logic [5:0]  mul_a;
    logic [5:0]  mul_b;
    logic [31:0] mul_c;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [5:0]  rsp_count;
    logic        busy;

    int n_checks;
    int n_fail;

    sc_mul_scheduler dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_count(rsp_count),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A stream: thermometer on a/2; B stream: thresholds bit-reversed for decorrelation.
    function automatic logic [31:0] sc_mul(input logic [5:0] a, input logic [5:0] b);
        logic [31:0] r;
        int rk;
        r = '0;
        for (int k = 0; k < 32; k++) begin
            rk = 0;
            for (int j = 0; j < 5; j++) rk = rk | (((k >> j) & 1) << (4 - j));
            r[k] = (int'(a) > 2 * k) && (int'(b) > 2 * rk);
        end
        return r;
    endfunction

    assign mul_c = sc_mul(mul_a, mul_b);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'hf;
        req_a = {4{6'd63}};
        req_b = {4{6'd63}};
        rsp_ready = 1'b1;
        step();
        n_checks++;
        if (req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_req_ready got %h exp 0", req_ready); end
        n_checks++;
        if ({mul_a, mul_b} !== 12'h0) begin n_fail++; $display("FAIL reset_mul got %h exp 0", {mul_a, mul_b}); end
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_count, busy} !== 10'h0) begin
            n_fail++; $display("FAIL reset_rsp got %h exp 0", {rsp_valid, rsp_id, rsp_count, busy});
        end
        step();
        rst = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_single();
        apply_reset();
        req_valid = 4'b0100;
        req_a = {6'd0, 6'd63, 6'd0, 6'd0};
        req_b = {6'd0, 6'd63, 6'd0, 6'd0};
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready got %b exp 0100", req_ready); end
        step();
        req_valid = '0;
        #1;
        n_checks++;
        if ({req_ready, mul_a, rsp_valid, busy} !== {4'b0, 6'd63, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL single_s1 ready=%b mul_a=%0d rsp_valid=%b busy=%b", req_ready, mul_a, rsp_valid, busy);
        end
        step();
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_count} !== {1'b1, 2'd2, 6'd32}) begin
            n_fail++; $display("FAIL single_rsp got v=%b id=%0d cnt=%0d exp v=1 id=2 cnt=32", rsp_valid, rsp_id, rsp_count);
        end
        step();
        n_checks++;
        if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL single_drain got v=%b busy=%b exp 0 0", rsp_valid, busy); end
    endtask

    task automatic test_operand_corners();
        logic [5:0] av [3];
        logic [5:0] bv [3];
        logic [5:0] ec [3];
        av = '{6'd0, 6'd32, 6'd63};
        bv = '{6'd63, 6'd63, 6'd0};
        ec = '{6'd0, 6'd16, 6'd0};
        apply_reset();
        for (int j = 0; j < 5; j++) begin
            req_valid = (j < 3) ? 4'b0001 : 4'b0000;
            req_a = {18'd0, (j < 3) ? av[j] : 6'd0};
            req_b = {18'd0, (j < 3) ? bv[j] : 6'd0};
            #1;
            if (j < 3) begin
                n_checks++;
                if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL corner_ready[%0d] got %b exp 0001", j, req_ready); end
            end
            if (j >= 2) begin
                n_checks++;
                if ({rsp_valid, rsp_id, rsp_count} !== {1'b1, 2'd0, ec[j-2]}) begin
                    n_fail++;
                    $display("FAIL corner_rsp[%0d] got v=%b id=%0d cnt=%0d exp v=1 id=0 cnt=%0d", j - 2, rsp_valid, rsp_id, rsp_count, ec[j-2]);
                end
            end
            step();
        end
    endtask

    task automatic test_fairness();
        logic [5:0] ec;
        apply_reset();
        req_a = {6'd44, 6'd36, 6'd28, 6'd20};
        req_b = {6'd36, 6'd44, 6'd52, 6'd60};
        for (int j = 0; j < 10; j++) begin
            req_valid = (j < 8) ? 4'hf : 4'h0;
            #1;
            n_checks++;
            if (req_ready !== ((j < 8) ? (4'b0001 << (j % 4)) : 4'b0000)) begin
                n_fail++; $display("FAIL fair_grant[%0d] got %b", j, req_ready);
            end
            if (j >= 2) begin
                ec = 6'($countones(sc_mul(req_a[((j-2)%4)*6 +: 6], req_b[((j-2)%4)*6 +: 6])));
                n_checks++;
                if ({rsp_valid, rsp_id, rsp_count} !== {1'b1, 2'((j - 2) % 4), ec}) begin
                    n_fail++;
                    $display("FAIL fair_rsp[%0d] got v=%b id=%0d cnt=%0d exp v=1 id=%0d cnt=%0d", j, rsp_valid, rsp_id, rsp_count, (j - 2) % 4, ec);
                end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int n_acc;
        apply_reset();
        n_acc = 0;
        rsp_ready = 1'b0;
        req_valid = 4'b0011;
        req_a = {6'd0, 6'd0, 6'd32, 6'd63};
        req_b = {6'd0, 6'd0, 6'd63, 6'd63};
        for (int j = 0; j < 5; j++) begin
            #1;
            if (req_ready != 4'b0) n_acc++;
            if (j >= 2) begin
                n_checks++;
                if ({req_ready, rsp_valid, rsp_id, rsp_count} !== {4'b0, 1'b1, 2'd0, 6'd32}) begin
                    n_fail++;
                    $display("FAIL bp_hold[%0d] ready=%b v=%b id=%0d cnt=%0d exp ready=0 v=1 id=0 cnt=32", j, req_ready, rsp_valid, rsp_id, rsp_count);
                end
            end
            step();
        end
        n_checks++;
        if (n_acc !== 2) begin n_fail++; $display("FAIL bp_accepts got %0d exp 2", n_acc); end
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_resume got %b exp 0001", req_ready); end
        step();
        req_valid = '0;
        #1;
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_count} !== {1'b1, 2'd1, 6'd16}) begin
            n_fail++; $display("FAIL bp_rsp1 got v=%b id=%0d cnt=%0d exp v=1 id=1 cnt=16", rsp_valid, rsp_id, rsp_count);
        end
        step();
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_count} !== {1'b1, 2'd0, 6'd32}) begin
            n_fail++; $display("FAIL bp_rsp2 got v=%b id=%0d cnt=%0d exp v=1 id=0 cnt=32", rsp_valid, rsp_id, rsp_count);
        end
        step();
        n_checks++;
        if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL bp_drain got v=%b busy=%b", rsp_valid, busy); end
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        req_valid = 4'b0011;
        req_a = {6'd50, 6'd40, 6'd30, 6'd20};
        req_b = {6'd63, 6'd63, 6'd63, 6'd63};
        step();
        step();
        req_valid = '0;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({rsp_valid, busy, req_ready} !== 6'b0) begin
            n_fail++; $display("FAIL mid_rst got v=%b busy=%b ready=%b exp 0", rsp_valid, busy, req_ready);
        end
        #1;
        rst = 1'b0;
        step();
        n_checks++;
        if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL mid_stale got v=%b busy=%b", rsp_valid, busy); end
        req_valid = 4'b1000;
        #1;
        n_checks++;
        if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL mid_grant got %b exp 1000", req_ready); end
        step();
        req_valid = '0;
        step();
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_count} !== {1'b1, 2'd3, 6'($countones(sc_mul(6'd50, 6'd63)))}) begin
            n_fail++; $display("FAIL mid_rsp got v=%b id=%0d cnt=%0d exp v=1 id=3", rsp_valid, rsp_id, rsp_count);
        end
        step();
    endtask

    task automatic test_skip_idle();
        apply_reset();
        req_a = {6'd63, 6'd10, 6'd32, 6'd5};
        req_b = {6'd63, 6'd10, 6'd63, 6'd5};
        for (int j = 0; j < 6; j++) begin
            req_valid = (j < 4) ? 4'b1010 : 4'b0000;
            #1;
            n_checks++;
            if (req_ready !== ((j < 4) ? ((j % 2 == 0) ? 4'b0010 : 4'b1000) : 4'b0000)) begin
                n_fail++; $display("FAIL skip_grant[%0d] got %b", j, req_ready);
            end
            if (j >= 2) begin
                n_checks++;
                if ({rsp_valid, rsp_id, rsp_count} !== ((j % 2 == 0) ? {1'b1, 2'd1, 6'd16} : {1'b1, 2'd3, 6'd32})) begin
                    n_fail++; $display("FAIL skip_rsp[%0d] got v=%b id=%0d cnt=%0d", j, rsp_valid, rsp_id, rsp_count);
                end
            end
            step();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        #1;
        test_reset();
        test_single();
        test_operand_corners();
        test_fairness();
        test_backpressure();
        test_reset_midflight();
        test_skip_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
